// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with hold timeout
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_d;
  logic [1:0] idx_d;
  logic       valid_d;
  logic       preempt_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       hold_done;
  logic       owner_req;

  assign hold_done = (hold_q == 8'(MAX_HOLD));
  assign owner_req = req[gnt_idx];

  // Rotating priority search starting at ptr; first set request wins
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output values; release causes checked e first
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    valid_d   = gnt_valid;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (e && win_found) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = 8'd1;
        end else begin
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!e || !owner_req || hold_done) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          valid_d   = 1'b0;
          ptr_d     = gnt_idx + 2'd1;
          hold_d    = 8'd0;
          // Only a forced release of a still-active, enabled owner is a preemption
          preempt_d = e && owner_req;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      hold_q    <= 8'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
      preempt   <= preempt_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed self-checking bench for rr_arbiter_4
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic       e;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter_4 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .e         (e),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e     = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    n_checks++;
    if (gnt_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", gnt_idx); end
    n_checks++;
    if (gnt_valid !== 1'b0 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got valid=%b preempt=%b expected 0 0", gnt_valid, preempt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    e   = 1'b1;
    req = 4'b1010;
    tick();
    n_checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || gnt_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_first: got gnt=%b idx=%0d valid=%b expected 0010 1 1", gnt, gnt_idx, gnt_valid);
    end
    req = 4'b1000;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd1 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL basic_release: got gnt=%b valid=%b idx=%0d preempt=%b expected 0000 0 1 0", gnt, gnt_valid, gnt_idx, preempt);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      n_fail++; $display("FAIL basic_second: got gnt=%b idx=%0d expected 1000 3", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      for (int c = 0; c < 2; c++) begin
        tick();
        n_checks++;
        if (gnt !== exp_g || preempt !== 1'b0) begin
          n_fail++; $display("FAIL rr_grant k=%0d c=%0d: got gnt=%b preempt=%b expected %b 0", k, c, gnt, preempt, exp_g);
        end
      end
      req = 4'b1111 & ~exp_g;
      tick();
      n_checks++;
      if (gnt !== 4'b0000 || preempt !== 1'b0) begin
        n_fail++; $display("FAIL rr_idle k=%0d: got gnt=%b preempt=%b expected 0000 0", k, gnt, preempt);
      end
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0001 || preempt !== 1'b0) begin
        n_fail++; $display("FAIL timeout_hold c=%0d: got gnt=%b preempt=%b expected 0001 0", c, gnt, preempt);
      end
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b1 || gnt_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_release: got gnt=%b preempt=%b valid=%b expected 0000 1 0", gnt, preempt, gnt_valid);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL timeout_regrant: got gnt=%b preempt=%b expected 0001 0", gnt, preempt);
    end
  endtask

  task automatic test_enable();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      n_fail++; $display("FAIL enable_grant2: got gnt=%b idx=%0d expected 0100 2", gnt, gnt_idx);
    end
    e   = 1'b0;
    req = 4'b1111;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL enable_release: got gnt=%b preempt=%b expected 0000 0", gnt, preempt);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
        n_fail++; $display("FAIL enable_blocked c=%0d: got gnt=%b valid=%b expected 0000 0", c, gnt, gnt_valid);
      end
    end
    e = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
      n_fail++; $display("FAIL enable_ptr3: got gnt=%b idx=%0d expected 1000 3", gnt, gnt_idx);
    end
  endtask

  task automatic test_wrap();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    req = 4'b1111;
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      n_fail++; $display("FAIL wrap_ignore_others: got gnt=%b idx=%0d expected 0100 2", gnt, gnt_idx);
    end
    req = 4'b0000;
    tick();
    req = 4'b0101;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
      n_fail++; $display("FAIL wrap_winner: got gnt=%b idx=%0d expected 0001 0", gnt, gnt_idx);
    end
  endtask

  task automatic test_timeout_edges();
    req = 4'b0000;
    tick();
    tick();
    req = 4'b0001;
    for (int c = 0; c < 8; c++) tick();
    e = 1'b0;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL edge_enable_timeout: got gnt=%b preempt=%b expected 0000 0", gnt, preempt);
    end
    e = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_fail++; $display("FAIL edge_regrant: got gnt=%b expected 0001", gnt);
    end
    for (int c = 0; c < 7; c++) tick();
    req = 4'b0000;
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL edge_drop_timeout: got gnt=%b preempt=%b expected 0000 0", gnt, preempt);
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0100;
    tick();
    n_checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin
      n_fail++; $display("FAIL areset_pre: got gnt=%b idx=%0d expected 0100 2", gnt, gnt_idx);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL areset_now: got gnt=%b idx=%0d valid=%b preempt=%b expected 0000 0 0 0", gnt, gnt_idx, gnt_valid, preempt);
    end
    #1;
    rst_n = 1'b1;
    req   = 4'b1000;
    e     = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || preempt !== 1'b0) begin
      n_fail++; $display("FAIL areset_after: got gnt=%b idx=%0d preempt=%b expected 1000 3 0", gnt, gnt_idx, preempt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_enable();
    test_wrap();
    test_timeout_edges();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, maximum consecutive cycles one grant may be held; legal range 2..255.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port e  input  1  arbiter enable; low blocks new grants and releases any current grant.
REQ-005 SHALL have port req  input  4  request vector, bit i from requester i; level-sensitive, held high while using the resource.
REQ-006 SHALL have port gnt  output  4  one-hot grant, registered; all-zero when nothing is granted.
REQ-007 SHALL have port gnt_idx  output  2  binary index of the granted requester (a1,a0 encoding); holds last value when gnt is zero.
REQ-008 SHALL have port gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 SHALL have port preempt  output  1  one-cycle pulse marking a timeout release.

Function
REQ-010 SHALL implement two states, IDLE and GRANT; all outputs are registered.
REQ-011 SHALL update, in IDLE with e=1 and req!=0, on that edge: state=GRANT, gnt=one-hot of winner, gnt_idx=winner, gnt_valid=1, hold_cnt=1; latency is 1 cycle from the sampled request.
REQ-012 SHALL pick as winner the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 SHALL stay in IDLE with gnt=0 when e=0 or req=0.
REQ-014 SHALL hold gnt unchanged in GRANT while req[gnt_idx]=1, e=1 and hold_cnt<MAX_HOLD, and increment hold_cnt each cycle.
REQ-015 SHALL release on the first edge in GRANT where req[gnt_idx]=0 or e=0 or hold_cnt=MAX_HOLD: state=IDLE, gnt=0, gnt_valid=0, ptr=gnt_idx+1 mod 4 (3 wraps to 0), hold_cnt=0.
REQ-016 SHALL assert preempt for exactly one cycle, coincident with gnt=0, only when the release cause was hold_cnt=MAX_HOLD while req[gnt_idx]=1 and e=1.
REQ-017 SHALL insert exactly one idle cycle (gnt=0) between any two grants, including a regrant to the same requester.
REQ-018 SHALL ignore changes on req bits other than gnt_idx during GRANT.
REQ-019 SHALL never have more than one gnt bit high in any cycle.
REQ-020 SHALL give the e=0 release priority over the timeout; preempt stays 0 when e=0 and timeout coincide.
REQ-021 SHALL release a requester dropping req on the same edge hold_cnt reaches MAX_HOLD without a preempt pulse.

Reset
REQ-022 SHALL, while rst_n=0 and independently of clk, force state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, preempt=0, ptr=0, hold_cnt=0.
REQ-023 SHALL abandon any grant in progress when reset is asserted mid-grant, without a preempt pulse.
REQ-024 SHALL evaluate requests on the first rising edge after rst_n deasserts; a deassertion coincident with an edge does not produce a grant on that edge.

Verification
REQ-025 SHALL cover: reset, e=1, req=4'b1010 -> next cycle gnt=4'b0010, gnt_idx=1; drop req[1] -> gnt=0, then gnt=4'b1000, gnt_idx=3.
REQ-026 SHALL cover: req=4'b1111 held, requesters dropping after 2 cycles each -> grant order 0,1,2,3,0 with one idle cycle between each, preempt=0 throughout.
REQ-027 SHALL cover: MAX_HOLD=8, req=4'b0001 held continuously -> gnt=4'b0001 for exactly 8 cycles, then gnt=0 with preempt=1 for 1 cycle, then gnt=4'b0001 again.
REQ-028 SHALL cover: grant to requester 2 active, e driven 0 -> next edge gnt=0, preempt=0, ptr=3; with e=0 and req=4'b1111 gnt stays 0.
REQ-029 SHALL cover: rst_n pulsed low mid-grant between clock edges -> gnt=0, gnt_idx=0, gnt_valid=0 immediately; after release, req=4'b1000 -> gnt=4'b1000 one cycle later.
REQ-030 SHALL cover: ptr=3 after granting requester 2, req=4'b0101 -> winner is requester 0 (wrap-around), gnt_idx=0.
